// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle unsigned restoring divider with start/done handshake
//
// Purpose: divides dividend by divisor one quotient bit per clock using a
// trial subtraction (add of the inverted divisor with carry-in 1). Results
// are registered and held until the next completed divide.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request a divide, sampled only while idle
//   dividend     unsigned dividend, latched when start is accepted
//   divisor      unsigned divisor, latched when start is accepted
//   busy         high while running and during the done cycle
//   done         one-cycle pulse, results valid
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend on divide by zero)
//   div_by_zero  registered, set with done when the divisor was zero
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] p_q;   // partial remainder
  logic [WIDTH-1:0] q_q;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q;   // latched divisor

  logic [WIDTH:0]   shift_in;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] q_d;

  // The guard bit lives only in the trial path: after a restore the partial
  // remainder is always below the divisor, so it fits in WIDTH bits between
  // iterations and only the shifted value can reach WIDTH+1 bits.
  always_comb begin
    shift_in = {p_q, q_q[WIDTH-1]};
    trial    = shift_in + {1'b1, ~d_q} + {{WIDTH{1'b0}}, 1'b1};
    borrow   = trial[WIDTH];
    p_d      = borrow ? shift_in[WIDTH-1:0] : trial[WIDTH-1:0];
    q_d      = {q_q[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_q  <= dividend;
            d_q  <= divisor;
            p_q  <= '0;
            busy <= 1'b1;
            if (divisor != '0) begin
              cnt_q   <= CW'(WIDTH);
              state_q <= S_RUN;
            end else begin
              // Divide by zero skips the iterations and reports immediately.
              state_q     <= S_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end

        S_RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            done        <= 1'b1;
            quotient    <= q_d;
            remainder   <= p_d;
            div_by_zero <= 1'b0;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed self-checking bench for restoring_divider
module tb_restoring_divider;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;
  int lat;
  int bcnt;

  restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives start at a negedge, then samples at each following negedge until
  // done is seen. lat is the number of edges from the drive point to done
  // (-1 if done never appears); bcnt counts the sampled cycles with busy high.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit hold,
                        output int lat_o, output int bcnt_o);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat_o    = -1;
    bcnt_o   = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold) begin
          dividend = 8'd50;
          divisor  = 8'd3;
        end else begin
          start = 1'b0;
        end
      end
      if (busy) bcnt_o++;
      if (done) begin
        lat_o = i + 1;
        break;
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 100 / 7 = 14 r 2, done after 9 edges, busy for 9 cycles
    do_div(8'd100, 8'd7, 1'b0, lat, bcnt);
    chk("a_lat", lat, 9);
    chk("a_busy_cnt", bcnt, 9);
    chk("a_quot", quotient, 14);
    chk("a_rem", remainder, 2);
    chk("a_dbz", div_by_zero, 0);
    @(negedge clk);
    chk("a_busy_after", busy, 0);
    chk("a_done_pulse", done, 0);
    chk("a_hold_quot", quotient, 14);

    do_div(8'd255, 8'd1, 1'b0, lat, bcnt);
    chk("b_lat", lat, 9);
    chk("b_quot", quotient, 255);
    chk("b_rem", remainder, 0);
    @(negedge clk);

    do_div(8'd5, 8'd9, 1'b0, lat, bcnt);
    chk("c_quot", quotient, 0);
    chk("c_rem", remainder, 5);
    @(negedge clk);

    do_div(8'd200, 8'd200, 1'b0, lat, bcnt);
    chk("d_quot", quotient, 1);
    chk("d_rem", remainder, 0);
    @(negedge clk);

    // divide by zero
    do_div(8'd37, 8'd0, 1'b0, lat, bcnt);
    chk("z_lat", lat, 1);
    chk("z_quot", quotient, 255);
    chk("z_rem", remainder, 37);
    chk("z_dbz", div_by_zero, 1);
    @(negedge clk);
    chk("z_busy_after", busy, 0);
    chk("z_hold_dbz", div_by_zero, 1);

    // start held high with operands changed after acceptance
    do_div(8'd100, 8'd7, 1'b1, lat, bcnt);
    chk("h_lat", lat, 9);
    chk("h_quot", quotient, 14);
    chk("h_rem", remainder, 2);
    chk("h_dbz_cleared", div_by_zero, 0);
    @(negedge clk);
    chk("h_idle_busy", busy, 0);
    chk("h_idle_done", done, 0);
    start = 1'b0;
    bcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) bcnt++;
    end
    chk("h_no_second", bcnt, 0);

    // reset in the middle of a divide
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("r_pre_busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_quot", quotient, 0);
    chk("r_rem", remainder, 0);
    chk("r_dbz", div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("r_idle", busy, 0);

    do_div(8'd9, 8'd2, 1'b0, lat, bcnt);
    chk("r2_lat", lat, 9);
    chk("r2_quot", quotient, 4);
    chk("r2_rem", remainder, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
